// File: rtl/seg7_scan_feeder_if.sv
// Display-feeder bus: value/dot load and frame handshake in, frame word and status out.
interface seg7_scan_feeder_if;
  logic [15:0] i_Value16;
  logic [3:0]  i_DotMask;
  logic        i_Load;
  logic        i_FrameDone;
  logic [15:0] o_Data16;
  logic [1:0]  o_DigitIdx;
  logic        o_Pending;

  modport master (
    output i_Value16, i_DotMask, i_Load, i_FrameDone,
    input  o_Data16, o_DigitIdx, o_Pending
  );

  modport slave (
    input  i_Value16, i_DotMask, i_Load, i_FrameDone,
    output o_Data16, o_DigitIdx, o_Pending
  );
endinterface

// File: rtl/seg7_scan_feeder.sv
// Multiplexes four hex digits onto a serial LED shifter frame word, one digit per
// DWELL_FRAMES frames, with new values applied only at the 3->0 scan boundary.
module seg7_scan_feeder #(
  parameter int DWELL_FRAMES = 16
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  seg7_scan_feeder_if.slave  bus
);
  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [7:0]  DWELL_LAST = 8'(DWELL_FRAMES - 1);
  localparam logic [15:0] BLANK_WORD = 16'h00FF;

  state_t      state, state_nxt;
  logic [15:0] pend_val, act_val, act_val_nxt;
  logic [3:0]  pend_dot, act_dot, act_dot_nxt;
  logic        pending;
  logic [7:0]  frame_cnt, cnt_nxt;
  logic [1:0]  digit_idx, digit_nxt;
  logic        apply, dwell_end, word_upd;
  logic [15:0] data_p1, word_nxt;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_encode = 7'h3F;
      4'h1: seg_encode = 7'h06;
      4'h2: seg_encode = 7'h5B;
      4'h3: seg_encode = 7'h4F;
      4'h4: seg_encode = 7'h66;
      4'h5: seg_encode = 7'h6D;
      4'h6: seg_encode = 7'h7D;
      4'h7: seg_encode = 7'h07;
      4'h8: seg_encode = 7'h7F;
      4'h9: seg_encode = 7'h6F;
      4'hA: seg_encode = 7'h77;
      4'hB: seg_encode = 7'h7C;
      4'hC: seg_encode = 7'h39;
      4'hD: seg_encode = 7'h5E;
      4'hE: seg_encode = 7'h79;
      default: seg_encode = 7'h71;
    endcase
  endfunction

  function automatic logic [15:0] frame_word(input logic [15:0] val, input logic [3:0] dot,
                                             input logic [1:0] idx);
    logic [3:0] nib;
    logic [3:0] sel;
    nib = 4'(val >> {idx, 2'b00});
    sel = ~(4'b0001 << idx);
    frame_word = {dot[idx], seg_encode(nib), 4'hF, sel};
  endfunction

  always_ff @(posedge i_CLK) begin
    if (i_RESET) state <= BLANK;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == BLANK && bus.i_FrameDone && pending) state_nxt = SCAN;
  end

  // Scan control: dwell counting, digit advance, and boundary application of the pending buffer.
  always_comb begin
    apply       = 1'b0;
    dwell_end   = 1'b0;
    cnt_nxt     = frame_cnt;
    digit_nxt   = digit_idx;
    if (bus.i_FrameDone) begin
      if (state == BLANK) begin
        apply = pending;
      end else begin
        dwell_end = (frame_cnt == DWELL_LAST);
        apply     = dwell_end && (digit_idx == 2'd3) && pending;
        cnt_nxt   = dwell_end ? 8'd0 : frame_cnt + 8'd1;
        digit_nxt = dwell_end ? digit_idx + 2'd1 : digit_idx;
      end
    end
    act_val_nxt = apply ? pend_val : act_val;
    act_dot_nxt = apply ? pend_dot : act_dot;
    word_upd    = bus.i_FrameDone && (state_nxt == SCAN);
    word_nxt    = frame_word(act_val_nxt, act_dot_nxt, digit_nxt);
  end

  // Registered frame word: changes only right after a frame latch, never mid-frame.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      pend_val  <= '0;
      pend_dot  <= '0;
      pending   <= 1'b0;
      act_val   <= '0;
      act_dot   <= '0;
      frame_cnt <= '0;
      digit_idx <= '0;
      data_p1   <= BLANK_WORD;
    end else begin
      if (bus.i_Load) begin
        pend_val <= bus.i_Value16;
        pend_dot <= bus.i_DotMask;
        pending  <= 1'b1;
      end else if (apply) begin
        pending  <= 1'b0;
      end
      act_val   <= act_val_nxt;
      act_dot   <= act_dot_nxt;
      frame_cnt <= cnt_nxt;
      digit_idx <= digit_nxt;
      if (word_upd) data_p1 <= word_nxt;
    end
  end

  assign bus.o_Data16   = data_p1;
  assign bus.o_DigitIdx = digit_idx;
  assign bus.o_Pending  = pending;
endmodule
